pwm_gpo: RTL and testbench
==========================

Name: pwm_gpo

Overview:
- Parametrised general-purpose output block for the FPGA top levels. Each channel is either a static output bit or a PWM output with its own duty cycle.
- Intended use: the Arty A7 RGB and plain LEDs, dimmed from software.
- Sits on the shared system bus as a word-addressed device with a one-cycle read response.

Parameters:
- NumChannels, 16, number of output channels (1..32).
- CounterWidth, 8, width of the PWM period counter and duty registers (2..16).
- PrescaleWidth, 16, width of the clock prescaler.
- InvertOut, 0, when 1 every bit of gp_o is inverted after all other logic (for active-low LEDs).

Ports:
- clk_sys_i  in  1  system clock.
- rst_sys_i  in  1  synchronous, active-high reset.
- req_i  in  1  bus request; one access per cycle, always accepted (no gnt).
- we_i  in  1  write enable.
- be_i  in  4  byte enables.
- addr_i  in  32  byte address; only addr_i[9:2] is decoded.
- wdata_i  in  32  write data.
- rvalid_o  out  1  read/write response, one cycle after req_i.
- rdata_o  out  32  read data, valid with rvalid_o.
- gp_o  out  NumChannels  registered channel outputs.

Behaviour:
- Register map, word offsets. Every field below is reset to 0.
  - 0x000 CTRL: bit0 EN.
  - 0x004 PERIOD: [CounterWidth-1:0].
  - 0x008 PRESCALE: [PrescaleWidth-1:0].
  - 0x00C STATIC: [NumChannels-1:0], static output values.
  - 0x010 MODE: [NumChannels-1:0]; 1 selects PWM, 0 selects static.
  - 0x014 COUNT: read-only, current period counter.
  - 0x100+4*i DUTY[i]: [CounterWidth-1:0], for i < NumChannels.
- Bus writes:
  - Byte enables are honoured per byte.
  - Bits above the field width are ignored.
  - Writes to unmapped or read-only offsets have no effect.
- Bus reads:
  - Unused upper bits read 0; unmapped offsets read 0.
  - rdata_o is registered and holds its value between accesses.
  - rvalid_o is asserted for every request, read or write, one cycle after req_i.
- Reset values: rvalid_o=0, rdata_o=0, gp_o={NumChannels{InvertOut}}, all counters and duty shadows 0.
- Prescaler:
  - When EN=1, psc counts 0..PRESCALE and then wraps to 0.
  - tick is asserted in the cycle where psc==PRESCALE. PRESCALE=0 gives a tick every cycle.
- Period counter:
  - cnt advances only on tick and counts 0..PERIOD.
  - On a tick with cnt==PERIOD, cnt wraps to 0; this event is named wrap.
  - The PWM period is (PERIOD+1)*(PRESCALE+1) clocks.
- Duty shadowing:
  - Each channel has duty_sh[i], loaded from DUTY[i] on wrap and also on the cycle EN goes 0->1.
  - A DUTY write therefore never glitches the current period.
  - Write and wrap in the same cycle: the shadow loads the old DUTY; the new value takes effect at the next wrap.
- Output function:
  - PWM channel: pwm[i] = EN && (cnt < duty_sh[i]).
  - duty_sh=0 gives a constant 0.
  - duty_sh > PERIOD gives a constant 1 while EN=1.
  - Static channel: STATIC[i], regardless of EN.
  - gp_o = registered (MODE ? pwm : STATIC) XOR InvertOut, i.e. one cycle after cnt/STATIC/MODE change.
- EN=0: psc and cnt are held at 0 and PWM channels output 0.
- Clearing EN mid-period:
  - Counters return to 0 on the next cycle.
  - Re-enabling starts a fresh period with freshly loaded shadows.
- PERIOD or PRESCALE written below the current count:
  - The counter keeps counting up to its field maximum, wraps to 0, then uses the new limit.
  - The counter is 'equal' compared, so the bench must check that it wraps on overflow as above, with no lock-up.
- Reset asserted mid-operation: all state returns to its reset value on the next edge; no partial-period output.

Test Plan:
1. Reset, then read every register -> all read 0. gp_o=0 with InvertOut=0, gp_o=all-ones with InvertOut=1. rvalid_o pulses exactly one cycle after each req_i.
2. Write STATIC=0xA5A5, MODE=0 -> gp_o=0xA5A5 on the second cycle after the write request; EN stays 0.
3. PERIOD=9, PRESCALE=0, DUTY[0]=3, MODE=1, EN=1 -> gp_o[0] high 3 clocks, low 7 clocks, repeating every 10 clocks. COUNT reads cycle 0..9.
4. Same setup with PRESCALE=3 -> period 40 clocks, high 12. Write DUTY[0]=7 mid-period -> the current period keeps 12 high; the next period is 28 high.
5. DUTY[1]=0 and DUTY[2]=10 with PERIOD=9 -> gp_o[1] is constantly 0 and gp_o[2] is constantly 1. Byte write with be_i=4'b0010 to STATIC changes only bits [15:8].
6. Clear EN mid-period -> PWM bits go 0 two cycles later and COUNT reads 0. Assert rst_sys_i during a period -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/pwm_gpo.sv
// General-purpose outputs with per-channel static/PWM selection, on the
// word-addressed system bus with a registered one-cycle response.
module pwm_gpo #(
  parameter int unsigned NumChannels   = 16,
  parameter int unsigned CounterWidth  = 8,
  parameter int unsigned PrescaleWidth = 16,
  parameter bit          InvertOut     = 1'b0
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_sys_i,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [3:0]             be_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            wdata_i,
  output logic                   rvalid_o,
  output logic [31:0]            rdata_o,
  output logic [NumChannels-1:0] gp_o
);

  logic                     en_q, en_d;
  logic [CounterWidth-1:0]  period_q, period_d;
  logic [PrescaleWidth-1:0] prescale_q, prescale_d;
  logic [NumChannels-1:0]   static_q, static_d;
  logic [NumChannels-1:0]   mode_q, mode_d;
  logic [CounterWidth-1:0]  duty_q [NumChannels];
  logic [CounterWidth-1:0]  duty_d [NumChannels];
  logic [CounterWidth-1:0]  duty_sh_q [NumChannels];
  logic [CounterWidth-1:0]  duty_sh_d [NumChannels];
  logic [PrescaleWidth-1:0] psc_q, psc_d;
  logic [CounterWidth-1:0]  cnt_q, cnt_d;
  logic [NumChannels-1:0]   gp_q, gp_d;
  logic                     rvalid_q;
  logic [31:0]              rdata_q;

  logic [7:0]             word;
  logic                   wr;
  logic                   duty_sel;
  logic [31:0]            be_mask;
  logic [31:0]            rd_word;
  logic [31:0]            merged;
  logic                   tick;
  logic                   wrap;
  logic [NumChannels-1:0] pwm;
  logic                   unused_bits;

  assign word     = addr_i[9:2];
  assign wr       = req_i & we_i;
  assign duty_sel = (word[7:6] == 2'b01);
  assign be_mask  = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};

  always_comb begin
    rd_word = '0;
    case (word)
      8'h00:   rd_word = 32'(en_q);
      8'h01:   rd_word = 32'(period_q);
      8'h02:   rd_word = 32'(prescale_q);
      8'h03:   rd_word = 32'(static_q);
      8'h04:   rd_word = 32'(mode_q);
      8'h05:   rd_word = 32'(cnt_q);
      default: ;
    endcase
    if (duty_sel) begin
      for (int unsigned i = 0; i < NumChannels; i++) begin
        if (word[5:0] == 6'(i)) rd_word = 32'(duty_q[i]);
      end
    end
  end

  // Byte-enable merge against the current (zero-extended) field value, so
  // upper bits beyond each field simply fall away on truncation.
  assign merged      = (rd_word & ~be_mask) | (wdata_i & be_mask);
  assign unused_bits = ^{addr_i[31:10], addr_i[1:0], merged};

  always_comb begin
    en_d       = en_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    static_d   = static_q;
    mode_d     = mode_q;
    for (int unsigned i = 0; i < NumChannels; i++) duty_d[i] = duty_q[i];
    if (wr) begin
      case (word)
        8'h00:   en_d       = merged[0];
        8'h01:   period_d   = merged[CounterWidth-1:0];
        8'h02:   prescale_d = merged[PrescaleWidth-1:0];
        8'h03:   static_d   = merged[NumChannels-1:0];
        8'h04:   mode_d     = merged[NumChannels-1:0];
        default: ;
      endcase
      if (duty_sel) begin
        for (int unsigned i = 0; i < NumChannels; i++) begin
          if (word[5:0] == 6'(i)) duty_d[i] = merged[CounterWidth-1:0];
        end
      end
    end
  end

  // Equality compares: a limit written below the running count lets the
  // counter run to its natural overflow before the new limit applies.
  always_comb begin
    tick  = 1'b0;
    wrap  = 1'b0;
    psc_d = '0;
    cnt_d = '0;
    if (en_q) begin
      tick  = (psc_q == prescale_q);
      psc_d = tick ? '0 : psc_q + PrescaleWidth'(1);
      cnt_d = cnt_q;
      if (tick) begin
        wrap  = (cnt_q == period_q);
        cnt_d = wrap ? '0 : cnt_q + CounterWidth'(1);
      end
    end
    // Shadows track DUTY while disabled, so enabling starts with fresh values.
    for (int unsigned i = 0; i < NumChannels; i++) begin
      duty_sh_d[i] = (wrap || !en_q) ? duty_q[i] : duty_sh_q[i];
      pwm[i]       = en_q && (cnt_q < duty_sh_q[i]);
    end
    gp_d = ((mode_q & pwm) | (~mode_q & static_q)) ^ {NumChannels{InvertOut}};
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      en_q       <= 1'b0;
      period_q   <= '0;
      prescale_q <= '0;
      static_q   <= '0;
      mode_q     <= '0;
      psc_q      <= '0;
      cnt_q      <= '0;
      gp_q       <= {NumChannels{InvertOut}};
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      for (int unsigned i = 0; i < NumChannels; i++) begin
        duty_q[i]    <= '0;
        duty_sh_q[i] <= '0;
      end
    end else begin
      en_q       <= en_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      static_q   <= static_d;
      mode_q     <= mode_d;
      psc_q      <= psc_d;
      cnt_q      <= cnt_d;
      gp_q       <= gp_d;
      rvalid_q   <= req_i;
      if (req_i && !we_i) rdata_q <= rd_word;
      for (int unsigned i = 0; i < NumChannels; i++) begin
        duty_q[i]    <= duty_d[i];
        duty_sh_q[i] <= duty_sh_d[i];
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign gp_o     = gp_q;

endmodule

// File: tb/tb_pwm_gpo.sv
// Bench for pwm_gpo: directed and randomized scenarios against an
// elapsed-time arithmetic model of counter and PWM outputs.
module tb_pwm_gpo;
  localparam int NC = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [3:0]    be = 4'h0;
  logic [31:0]   addr = 32'h0;
  logic [31:0]   wdata = 32'h0;
  logic          rvalid, rvalid_n;
  logic [31:0]   rdata, rdata_n;
  logic [NC-1:0] gp, gp_n;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int base = 0;

  int            m_period, m_presc, kw;
  logic [NC-1:0] m_static, m_mode;
  int            duty_old [NC];
  int            duty_new [NC];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pwm_gpo #(.NumChannels(NC), .CounterWidth(8), .PrescaleWidth(16), .InvertOut(1'b0)) dut (
    .clk_sys_i(clk), .rst_sys_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .gp_o(gp));

  pwm_gpo #(.NumChannels(NC), .CounterWidth(8), .PrescaleWidth(16), .InvertOut(1'b1)) dut_n (
    .clk_sys_i(clk), .rst_sys_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .rvalid_o(rvalid_n), .rdata_o(rdata_n), .gp_o(gp_n));

  // Counter value k cycles after the enabling edge.
  function automatic int exp_cnt(input int k);
    return (k / (m_presc + 1)) % (m_period + 1);
  endfunction

  // Output seen k cycles after enable reflects cycle k-1; a period's duty is
  // the DUTY value held in the last cycle of the previous period.
  function automatic logic [NC-1:0] exp_gp(input int k);
    logic [NC-1:0] pw;
    int c, t, sc, d;
    pw = '0;
    if (k > 0) begin
      c  = k - 1;
      t  = (m_period + 1) * (m_presc + 1);
      sc = (c / t) * t - 1;
      for (int i = 0; i < NC; i++) begin
        d = (sc > kw) ? duty_new[i] : duty_old[i];
        pw[i] = (exp_cnt(c) < d);
      end
    end
    return (m_mode & pw) | (~m_mode & m_static);
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    @(negedge clk);
    req = 1'b0; we = 1'b0; be = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
    req = 1'b1; we = 1'b0; addr = a; be = 4'h0;
    @(negedge clk);
    req = 1'b0;
    d = rdata; v = rvalid;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic model_clear();
    m_period = 0; m_presc = 0; m_static = '0; m_mode = '0; kw = 32'h3fff_ffff;
    for (int i = 0; i < NC; i++) begin duty_old[i] = 0; duty_new[i] = 0; end
  endtask

  task automatic configure();
    bus_write(32'h004, 32'(m_period), 4'hF);
    bus_write(32'h008, 32'(m_presc), 4'hF);
    bus_write(32'h00C, 32'(m_static), 4'hF);
    bus_write(32'h010, 32'(m_mode), 4'hF);
    for (int i = 0; i < NC; i++) bus_write(32'h100 + 32'(4 * i), 32'(duty_old[i]), 4'hF);
    duty_new = duty_old;
  endtask

  task automatic enable();
    bus_write(32'h000, 32'h1, 4'hF);
    base = cyc;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    logic [31:0] offs [9];
    offs = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h014, 32'h100, 32'h13C, 32'h0FC};
    do_reset();
    n_tests++; if (gp !== 16'h0000) begin n_fail++; $display("FAIL reset_gp got=%h exp=%h", gp, 16'h0000); end
    n_tests++; if (gp_n !== 16'hFFFF) begin n_fail++; $display("FAIL reset_gp_inv got=%h exp=%h", gp_n, 16'hFFFF); end
    n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    for (int i = 0; i < 9; i++) begin
      bus_read(offs[i], d, v);
      n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_read[%h] got=%h exp=0", offs[i], d); end
      n_tests++; if (v !== 1'b1) begin n_fail++; $display("FAIL reset_rvalid_rd[%h] got=%b exp=1", offs[i], v); end
    end
    @(negedge clk);
    n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_idle got=%b exp=0", rvalid); end
  endtask

  task automatic test_static();
    logic [31:0] d;
    logic v;
    do_reset();
    bus_write(32'h00C, 32'h0000_A5A5, 4'hF);
    n_tests++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL static_wr_rvalid got=%b exp=1", rvalid); end
    n_tests++; if (gp !== 16'h0000) begin n_fail++; $display("FAIL static_early got=%h exp=%h", gp, 16'h0000); end
    @(negedge clk);
    n_tests++; if (gp !== 16'hA5A5) begin n_fail++; $display("FAIL static_gp got=%h exp=%h", gp, 16'hA5A5); end
    n_tests++; if (gp_n !== 16'h5A5A) begin n_fail++; $display("FAIL static_gp_inv got=%h exp=%h", gp_n, 16'h5A5A); end
    bus_read(32'h000, d, v);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL static_en got=%h exp=0", d); end
    bus_read(32'h00C, d, v);
    n_tests++; if (d !== 32'h0000_A5A5) begin n_fail++; $display("FAIL static_rd got=%h exp=%h", d, 32'hA5A5); end
  endtask

  task automatic test_pwm_basic();
    logic [31:0] d;
    logic v;
    int k, highs;
    do_reset(); model_clear();
    m_period = 9; m_presc = 0; m_mode = 16'h0001; duty_old[0] = 3;
    configure(); enable();
    highs = 0;
    for (int n = 0; n < 30; n++) begin
      k = cyc - base;
      if (k >= 1 && k <= 10 && gp[0]) highs++;
      n_tests++; if (gp !== exp_gp(k)) begin n_fail++; $display("FAIL pwm_basic_gp k=%0d got=%h exp=%h", k, gp, exp_gp(k)); end
      bus_read(32'h014, d, v);
      n_tests++; if (d !== 32'(exp_cnt(k))) begin n_fail++; $display("FAIL pwm_basic_count k=%0d got=%0d exp=%0d", k, d, exp_cnt(k)); end
    end
    n_tests++; if (highs != 3) begin n_fail++; $display("FAIL pwm_basic_highs got=%0d exp=3", highs); end
  endtask

  task automatic test_prescale_duty_update();
    int k, h0, h1;
    do_reset(); model_clear();
    m_period = 9; m_presc = 3; m_mode = 16'h0001; duty_old[0] = 3;
    configure(); enable();
    kw = 15; duty_new[0] = 7;
    h0 = 0; h1 = 0;
    for (int n = 0; n < 120; n++) begin
      k = cyc - base;
      if (k >= 1 && k <= 40 && gp[0]) h0++;
      if (k >= 41 && k <= 80 && gp[0]) h1++;
      n_tests++; if (gp !== exp_gp(k)) begin n_fail++; $display("FAIL presc_gp k=%0d got=%h exp=%h", k, gp, exp_gp(k)); end
      if (k == 15) begin req = 1'b1; we = 1'b1; addr = 32'h100; wdata = 32'h7; be = 4'hF; end
      else begin req = 1'b0; we = 1'b0; be = 4'h0; end
      @(negedge clk);
    end
    n_tests++; if (h0 != 12) begin n_fail++; $display("FAIL presc_high_p0 got=%0d exp=12", h0); end
    n_tests++; if (h1 != 28) begin n_fail++; $display("FAIL presc_high_p1 got=%0d exp=28", h1); end
  endtask

  task automatic test_duty_extremes();
    int k;
    do_reset(); model_clear();
    m_period = 9; m_mode = 16'h0006; duty_old[1] = 0; duty_old[2] = 10;
    configure(); enable();
    for (int n = 0; n < 25; n++) begin
      k = cyc - base;
      if (k >= 1) begin
        n_tests++; if (gp[1] !== 1'b0) begin n_fail++; $display("FAIL duty_zero k=%0d got=%b exp=0", k, gp[1]); end
        n_tests++; if (gp[2] !== 1'b1) begin n_fail++; $display("FAIL duty_over k=%0d got=%b exp=1", k, gp[2]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d;
    logic v;
    do_reset();
    bus_write(32'h00C, 32'h0000_1234, 4'hF);
    bus_write(32'h00C, 32'hFFFF_FFFF, 4'b0010);
    bus_read(32'h00C, d, v);
    n_tests++; if (d !== 32'h0000_FF34) begin n_fail++; $display("FAIL be_static got=%h exp=%h", d, 32'hFF34); end
    n_tests++; if (gp !== 16'hFF34) begin n_fail++; $display("FAIL be_gp got=%h exp=%h", gp, 16'hFF34); end
    bus_write(32'h004, 32'hFFFF_FF05, 4'hF);
    bus_read(32'h004, d, v);
    n_tests++; if (d !== 32'h05) begin n_fail++; $display("FAIL period_trunc got=%h exp=%h", d, 32'h05); end
    bus_write(32'h014, 32'h55, 4'hF);
    bus_read(32'h014, d, v);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL count_ro got=%h exp=0", d); end
    bus_write(32'h018, 32'hFFFF_FFFF, 4'hF);
    bus_read(32'h018, d, v);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped got=%h exp=0", d); end
    bus_write(32'h13C, 32'h0000_01AB, 4'hF);
    bus_read(32'h13C, d, v);
    n_tests++; if (d !== 32'hAB) begin n_fail++; $display("FAIL duty15 got=%h exp=%h", d, 32'hAB); end
  endtask

  task automatic test_period_shrink();
    logic [31:0] d;
    logic v;
    int m, e;
    do_reset(); model_clear();
    m_period = 9;
    configure(); enable();
    repeat (7) @(negedge clk);
    bus_write(32'h004, 32'h3, 4'hF);
    for (int j = 0; j < 262; j++) begin
      m = cyc - base;
      e = (m <= 255) ? m : (m - 256) % 4;
      bus_read(32'h014, d, v);
      n_tests++; if (d !== 32'(e)) begin n_fail++; $display("FAIL shrink_count m=%0d got=%0d exp=%0d", m, d, e); end
    end
  endtask

  task automatic test_random();
    int k, t;
    for (int r = 0; r < 3; r++) begin
      do_reset(); model_clear();
      m_period = $urandom_range(2, 12);
      m_presc  = $urandom_range(0, 3);
      m_mode   = 16'($urandom);
      m_static = 16'($urandom);
      for (int i = 0; i < NC; i++) duty_old[i] = $urandom_range(0, m_period + 2);
      configure(); enable();
      t = (m_period + 1) * (m_presc + 1);
      for (int n = 0; n < 2 * t + 4; n++) begin
        k = cyc - base;
        n_tests++; if (gp !== exp_gp(k)) begin n_fail++; $display("FAIL rand_gp r=%0d k=%0d got=%h exp=%h", r, k, gp, exp_gp(k)); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_disable_reset();
    logic [31:0] d;
    logic v;
    int k;
    do_reset(); model_clear();
    m_period = 9; m_mode = 16'h0005; m_static = 16'h00F0; duty_old[0] = 5; duty_old[2] = 10;
    configure(); enable();
    repeat (5) @(negedge clk);
    n_tests++; if (gp !== exp_gp(5)) begin n_fail++; $display("FAIL dis_before got=%h exp=%h", gp, exp_gp(5)); end
    bus_write(32'h000, 32'h0, 4'hF);
    n_tests++; if (gp !== exp_gp(6)) begin n_fail++; $display("FAIL dis_one got=%h exp=%h", gp, exp_gp(6)); end
    @(negedge clk);
    n_tests++; if (gp !== 16'h00F0) begin n_fail++; $display("FAIL dis_two got=%h exp=%h", gp, 16'h00F0); end
    bus_read(32'h014, d, v);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL dis_count got=%h exp=0", d); end
    bus_write(32'h100, 32'h2, 4'hF);
    duty_old[0] = 2; duty_new = duty_old;
    bus_read(32'h00C, d, v);
    enable();
    for (int n = 0; n < 15; n++) begin
      k = cyc - base;
      n_tests++; if (gp !== exp_gp(k)) begin n_fail++; $display("FAIL reen_gp k=%0d got=%h exp=%h", k, gp, exp_gp(k)); end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (gp !== 16'h0000) begin n_fail++; $display("FAIL midrst_gp got=%h exp=%h", gp, 16'h0000); end
    n_tests++; if (gp_n !== 16'hFFFF) begin n_fail++; $display("FAIL midrst_gp_inv got=%h exp=%h", gp_n, 16'hFFFF); end
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata got=%h exp=0", rdata); end
    n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid got=%b exp=0", rvalid); end
    rst = 1'b0;
    bus_read(32'h000, d, v);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_en got=%h exp=0", d); end
    bus_read(32'h014, d, v);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_count got=%h exp=0", d); end
    bus_read(32'h00C, d, v);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_static got=%h exp=0", d); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_static();
    test_pwm_basic();
    test_prescale_duty_update();
    test_duty_extremes();
    test_byte_enable();
    test_period_shrink();
    test_random();
    test_disable_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
